// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: shift encodings, PC read-ahead offsets and
// the bit positions of the data-processing fields that the operand path decodes.
package cpu_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    CLS_IMM_SHIFT = 2'b00,
    CLS_REG_SHIFT = 2'b01,
    CLS_ROT_IMM   = 2'b10
  } op_class_e;

  localparam logic [31:0] PC_OFFSET_IMM = 32'd8;
  localparam logic [31:0] PC_OFFSET_REG = 32'd12;

  localparam int CLASS_HI      = 27;
  localparam int CLASS_LO      = 25;
  localparam int BIT_REG_SHIFT = 4;
  localparam int BIT_MUL_EXT   = 7;
  localparam int RM_HI         = 3;
  localparam int RM_LO         = 0;
  localparam int RS_HI         = 11;
  localparam int RS_LO         = 8;
  localparam int SHTYPE_HI     = 6;
  localparam int SHTYPE_LO     = 5;
  localparam int SHAMT_HI      = 11;
  localparam int SHAMT_LO      = 7;
  localparam int IMM8_HI       = 7;
  localparam int IMM8_LO       = 0;

  localparam logic [3:0] REG_PC = 4'hF;

  function automatic logic [31:0] pc_read(input logic [31:0] pc, input logic [31:0] offset);
    return pc + offset;
  endfunction

endpackage

// File: rtl/operand_class_decode.sv
// Classifies an instruction word into the operand class it needs from the
// register file, or flags it as outside the data-processing space.
module operand_class_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        imm_shift_o,
  output logic        reg_shift_o,
  output logic        rot_imm_o,
  output logic        err_o
);

  logic [2:0] cls;
  logic       dp_reg_form;
  logic       bit4;
  logic       bit7;
  logic       unused_bits;

  assign cls         = instr_i[CLASS_HI:CLASS_LO];
  assign dp_reg_form = (cls == 3'b000);
  assign bit4        = instr_i[BIT_REG_SHIFT];
  assign bit7        = instr_i[BIT_MUL_EXT];

  assign imm_shift_o = dp_reg_form && !bit4;
  assign reg_shift_o = dp_reg_form && bit4 && !bit7;
  assign rot_imm_o   = (cls == 3'b001);
  // bit4 with bit7 set lands in the multiply / extension space
  assign err_o       = (cls[2:1] != 2'b00) || (dp_reg_form && bit4 && bit7);

  assign unused_bits = ^{instr_i[31:28], instr_i[24:8], instr_i[6:5], instr_i[3:0]};

endmodule

// File: rtl/shift_operand_sequencer.sv
// Sequences register-file reads for one data-processing instruction at a time
// and holds a registered operand bundle for the barrel shifter until consumed.
module shift_operand_sequencer
  import cpu_pkg::*;
(
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [3:0]  rf_addr_a_o,
  input  logic [31:0] rf_data_a_i,
  output logic [3:0]  rf_addr_b_o,
  input  logic [31:0] rf_data_b_i,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [31:0] b_bus_o,
  output logic [1:0]  shift_type_o,
  output logic [4:0]  shift_amount_imm_o,
  output logic [7:0]  shift_amount_reg_o,
  output logic        reg_shift_o,
  output logic        decode_err_o
);

  // state     | meaning
  // S_IDLE    | waiting for an instruction
  // S_RS_READ | sampling Rs for a register-specified shift amount
  // S_RM_READ | sampling Rm / immediate and building the bundle
  // S_ISSUE   | bundle valid, held until op_ready
  // S_ERR     | one-cycle decode error pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_RS_READ,
    S_RM_READ,
    S_ISSUE,
    S_ERR
  } state_e;

  state_e      state_q;
  logic [11:0] instr_q;
  logic [31:0] pc_q;
  op_class_e   class_q;

  logic        op_valid_q;
  logic        decode_err_q;
  logic [31:0] b_bus_q;
  shift_type_e shift_type_q;
  logic [4:0]  shift_amount_imm_q;
  logic [7:0]  shift_amount_reg_q;
  logic        reg_shift_q;

  logic        dec_imm_shift;
  logic        dec_reg_shift;
  logic        dec_rot_imm;
  logic        dec_err;
  op_class_e   class_d;

  logic        rm_is_pc;
  logic        rs_is_pc;
  logic [31:0] pc_imm_read;
  logic [31:0] pc_reg_read;
  logic [7:0]  rs_amount_d;
  logic        unused_rs_hi;

  operand_class_decode u_decode (
    .instr_i     (instr_i),
    .imm_shift_o (dec_imm_shift),
    .reg_shift_o (dec_reg_shift),
    .rot_imm_o   (dec_rot_imm),
    .err_o       (dec_err)
  );

  always_comb begin
    class_d = CLS_IMM_SHIFT;
    if (dec_rot_imm) begin
      class_d = CLS_ROT_IMM;
    end else if (dec_reg_shift) begin
      class_d = CLS_REG_SHIFT;
    end
  end

  assign instr_ready_o = (state_q == S_IDLE) && !flush_i && !rst_i;

  assign rf_addr_a_o = instr_q[RM_HI:RM_LO];
  assign rf_addr_b_o = instr_q[RS_HI:RS_LO];

  assign rm_is_pc    = (instr_q[RM_HI:RM_LO] == REG_PC);
  assign rs_is_pc    = (instr_q[RS_HI:RS_LO] == REG_PC);
  assign pc_imm_read = pc_read(pc_q, PC_OFFSET_IMM);
  assign pc_reg_read = pc_read(pc_q, PC_OFFSET_REG);
  // Rs == PC is unpredictable architecturally; pinned to the register-shift read-ahead
  assign rs_amount_d = rs_is_pc ? pc_reg_read[7:0] : rf_data_b_i[7:0];
  assign unused_rs_hi = ^rf_data_b_i[31:8];

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q            <= S_IDLE;
      instr_q            <= '0;
      pc_q               <= '0;
      class_q            <= CLS_IMM_SHIFT;
      op_valid_q         <= 1'b0;
      decode_err_q       <= 1'b0;
      b_bus_q            <= '0;
      shift_type_q       <= SHIFT_LSL;
      shift_amount_imm_q <= '0;
      shift_amount_reg_q <= '0;
      reg_shift_q        <= 1'b0;
    end else if (flush_i) begin
      state_q      <= S_IDLE;
      op_valid_q   <= 1'b0;
      decode_err_q <= 1'b0;
    end else begin
      decode_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid_i) begin
            instr_q <= instr_i[11:0];
            pc_q    <= pc_i;
            class_q <= class_d;
            if (dec_err) begin
              state_q      <= S_ERR;
              decode_err_q <= 1'b1;
            end else if (dec_imm_shift || dec_rot_imm) begin
              state_q <= S_RM_READ;
            end else begin
              state_q <= S_RS_READ;
            end
          end
        end
        S_RS_READ: begin
          shift_amount_reg_q <= rs_amount_d;
          state_q            <= S_RM_READ;
        end
        S_RM_READ: begin
          unique case (class_q)
            CLS_REG_SHIFT: begin
              b_bus_q            <= rm_is_pc ? pc_reg_read : rf_data_a_i;
              shift_type_q       <= shift_type_e'(instr_q[SHTYPE_HI:SHTYPE_LO]);
              shift_amount_imm_q <= '0;
              reg_shift_q        <= 1'b1;
            end
            CLS_ROT_IMM: begin
              b_bus_q            <= {24'b0, instr_q[IMM8_HI:IMM8_LO]};
              shift_type_q       <= SHIFT_ROR;
              shift_amount_imm_q <= {instr_q[RS_HI:RS_LO], 1'b0};
              reg_shift_q        <= 1'b0;
            end
            default: begin
              b_bus_q            <= rm_is_pc ? pc_imm_read : rf_data_a_i;
              shift_type_q       <= shift_type_e'(instr_q[SHTYPE_HI:SHTYPE_LO]);
              shift_amount_imm_q <= instr_q[SHAMT_HI:SHAMT_LO];
              reg_shift_q        <= 1'b0;
            end
          endcase
          op_valid_q <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (op_ready_i) begin
            op_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign op_valid_o         = op_valid_q;
  assign decode_err_o       = decode_err_q;
  assign b_bus_o            = b_bus_q;
  assign shift_type_o       = shift_type_q;
  assign shift_amount_imm_o = shift_amount_imm_q;
  assign shift_amount_reg_o = shift_amount_reg_q;
  assign reg_shift_o        = reg_shift_q;

endmodule
